// File: rtl/temp_display_pkg.sv
// Shared types and constants for the temperature display stage.
// Holds the conversion FSM encoding and the active-low seven-segment decode.
package temp_display_pkg;

    localparam int DIGITS = 3;
    localparam int IN_W   = 9;
    localparam int BCD_W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/temp_display_bin2bcd_seq.sv
// Iterative double-dabble: 9-bit binary to three BCD digits, one shift per cycle.
// Latency 10 cycles from start to done; start outside IDLE is ignored (no backpressure).
module bin2bcd_seq
    import temp_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    logic [1:0]       state;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] adj;
    logic [IN_W-1:0]  sr;
    logic [3:0]       cnt;

    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            sr    <= '0;
            cnt   <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr    <= bin;
                        acc   <= '0;
                        cnt   <= 4'(IN_W);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc <= {adj[BCD_W-2:0], sr[IN_W-1]};
                    sr  <= {sr[IN_W-2:0], 1'b0};
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    bcd   <= acc;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/temp_display.sv
// Periodic BCD conversion of promedio driving a 3-digit multiplexed active-low display.
// Latency: bcd/valid 10 cycles after each update tick; display registers lag by 1 cycle; no backpressure.
// Leading-zero blanking is enabled by defining TEMP_DISPLAY_BLANK_EN.
module temp_display
    import temp_display_pkg::*;
#(
    parameter int UPDATE_DIV = 5_000_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  promedio,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic [11:0] bcd,
    output logic        valid
);

    localparam int UW = $clog2(UPDATE_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    if (UPDATE_DIV < 16) begin : g_bad_update_div
        $error("UPDATE_DIV must be at least 16");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 2");
    end

    logic [UW-1:0] upd_cnt;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic          tick;
    logic [3:0]    digit;
    logic          blank;

    assign tick = (upd_cnt == UW'(UPDATE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_cnt <= '0;
        end else if (tick) begin
            upd_cnt <= '0;
        end else begin
            upd_cnt <= upd_cnt + 1'b1;
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (tick),
        .bin   (promedio),
        .bcd   (bcd),
        .done  (valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        case (idx)
            2'd1:    digit = bcd[7:4];
            2'd2:    digit = bcd[11:8];
            default: digit = bcd[3:0];
        endcase
`ifdef TEMP_DISPLAY_BLANK_EN
        // Tens only blanks when the whole upper part is zero, so "105" keeps its 0.
        blank = ((idx == 2'd2) && (bcd[11:8] == 4'd0)) ||
                ((idx == 2'd1) && (bcd[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 3'b111;
            seg <= SEG_BLANK;
        end else if (blank) begin
            an  <= 3'b111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(3'b001 << idx);
            seg <= seg_decode(digit);
        end
    end

endmodule

// File: tb/tb_temp_display.sv
// Directed and table-driven checks of temp_display with UPDATE_DIV=16, SCAN_DIV=4.
module tb_temp_display;

    localparam int UD = 16;
    localparam int SD = 4;
    localparam int NV = 8;

    typedef struct {
        logic [8:0]  p;
        logic [11:0] exp_bcd;
        logic [6:0]  su;
        logic [6:0]  st;
        logic [6:0]  sh;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [8:0]  promedio;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic [11:0] bcd;
    logic        valid;

    int tests;
    int fails;
    int k;
    vec_t vec [NV];

    temp_display #(.UPDATE_DIV(UD), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .promedio (promedio),
        .seg      (seg),
        .an       (an),
        .bcd      (bcd),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, got hang expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_valid: got no valid within %0d cycles expected a pulse", budget);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_scan(input vec_t v);
        int slot;
        logic [2:0] ea;
        logic [6:0] es;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            slot = ((k - 1) / SD) % 3;
            case (slot)
                1:       begin ea = 3'b101; es = v.st; end
                2:       begin ea = 3'b011; es = v.sh; end
                default: begin ea = 3'b110; es = v.su; end
            endcase
`ifdef TEMP_DISPLAY_BLANK_EN
            if ((slot == 2 && v.exp_bcd[11:8] == 4'd0) ||
                (slot == 1 && v.exp_bcd[11:4] == 8'd0)) begin
                ea = 3'b111;
                es = 7'h7F;
            end
`endif
            chk($sformatf("scan_an p=%0d k=%0d", v.p, k), 32'(an), 32'(ea));
            chk($sformatf("scan_seg p=%0d k=%0d", v.p, k), 32'(seg), 32'(es));
        end
    endtask

    initial begin
        bit ok;
        int last_k;
        int r;

        tests = 0;
        fails = 0;
        vec[0] = '{9'd255, 12'h255, 7'h12, 7'h12, 7'h24};
        vec[1] = '{9'd511, 12'h511, 7'h79, 7'h79, 7'h12};
        vec[2] = '{9'd0,   12'h000, 7'h40, 7'h40, 7'h40};
        vec[3] = '{9'd7,   12'h007, 7'h78, 7'h40, 7'h40};
        vec[4] = '{9'd100, 12'h100, 7'h40, 7'h40, 7'h79};
        vec[5] = '{9'd399, 12'h399, 7'h10, 7'h10, 7'h30};
        vec[6] = '{9'd42,  12'h042, 7'h24, 7'h19, 7'h40};
        vec[7] = '{9'd68,  12'h068, 7'h00, 7'h02, 7'h40};

        rst = 1'b0;
        promedio = vec[0].p;
        repeat (3) @(negedge clk);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_an", 32'(an), 32'h7);
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);

        rst = 1'b1;
        @(negedge clk);
        chk("first_edge_an", 32'(an), 32'h6);
        chk("first_edge_seg", 32'(seg), 32'h40);

        for (int i = 0; i < NV; i++) begin
            wait_valid(40, ok);
            if (ok) begin
                if (i == 0)
                    chk("first_valid_latency", 32'(k), 32'(UD + 10));
                chk($sformatf("bcd p=%0d", vec[i].p), 32'(bcd), 32'(vec[i].exp_bcd));
                if (i + 1 < NV)
                    promedio = vec[i + 1].p;
                @(negedge clk);
                chk($sformatf("valid_fall p=%0d", vec[i].p), 32'(valid), 32'h0);
                check_scan(vec[i]);
            end
        end

        // Input change after capture must not disturb the conversion in flight.
        wait_valid(40, ok);
        promedio = 9'd100;
        repeat (9) @(posedge clk);
        #1 promedio = 9'd399;
        wait_valid(40, ok);
        chk("held_capture_bcd", 32'(bcd), 32'h100);
        wait_valid(40, ok);
        chk("next_capture_bcd", 32'(bcd), 32'h399);

        // Reset in the middle of a conversion.
        repeat (11) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midreset_seg", 32'(seg), 32'h7F);
        chk("midreset_an", 32'(an), 32'h7);
        chk("midreset_bcd", 32'(bcd), 32'h0);
        chk("midreset_valid", 32'(valid), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_valid(40, ok);
        chk("post_reset_latency", 32'(k), 32'(UD + 10));
        chk("post_reset_bcd", 32'(bcd), 32'h399);

        void'($urandom(32'd20240611));
        last_k = k;
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 511));
            promedio = 9'(r);
            wait_valid(40, ok);
            if (!ok) break;
            chk($sformatf("rand_bcd v=%0d", r), 32'(bcd), 32'(ref_bcd(r)));
            chk("rand_valid_period", 32'(k - last_k), 32'(UD));
            last_k = k;
            @(negedge clk);
            chk("rand_valid_width", 32'(valid), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
